counter_share_arb: RTL
======================

Name: counter_share_arb

Overview:
- Round-robin scheduler that shares one CNT_W-bit up-counter among NUM_REQ requesters.
- Each requester asks for a run of a given length (target value). The block grants the counter to one requester at a time, sequences the count from 0 to target, and signals completion with a four-phase req/done handshake.
- Sits between client blocks needing timed intervals and the shared counter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- CNT_W, 3, counter and target width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester level request; held high until done observed.
- tgt  input  NUM_REQ*CNT_W  per-requester target; slice i = tgt[i*CNT_W +: CNT_W].
- grant  output  NUM_REQ  one-hot owner of the counter; all-zero when idle.
- count  output  CNT_W  current counter value.
- busy  output  1  high in RUN or DONE.
- done  output  1  high while in DONE (run complete, waiting for req drop).
- done_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; grant=0, count=0, busy=0, done=0, done_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- State machine: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - If req!=0, choose the first set bit searching upward from (last+1) mod NUM_REQ, wrapping.
  - On the next edge: grant=onehot(sel), done_id=sel, latch tgt slice into internal tgt_q, count=0, state=RUN.
  - If req==0, hold all outputs.
- RUN, each edge:
  - If count==tgt_q: state=DONE, done=1, count holds.
  - Else: count=count+1.
  - count never wraps because it stops at tgt_q <= 2^CNT_W-1.
- Latency: req sampled at edge 0 -> grant at edge 1 -> done at edge tgt+2.
  - tgt=0 gives done at edge 2.
  - tgt=7 (CNT_W=3) gives done at edge 9 with count=7.
- DONE:
  - grant, count and done_id hold.
  - When req[done_id]==0 on an edge: state=IDLE, grant=0, done=0, count=0, last=done_id.
  - Arbitration resumes from IDLE on the following edge. There is one idle cycle minimum between grants.
- Requests from other requesters during RUN/DONE are ignored; they stay pending and are arbitrated in IDLE.
- tgt changes after the grant edge do not affect the current run.
- Simultaneous requests: strict rotation. With req=1111 held, grants go 0,1,2,3,0.
- A requester re-raising req in the same cycle it dropped is treated as a new request; round robin places it last.
- rst_n low mid-run: immediate return to reset values. No done is issued for the interrupted run.

Optional Feature:
- Macro: COUNTER_SHARE_ARB_ABORT_EN.
- Defined:
  - In RUN, if req[done_id]==0 on an edge, the run aborts.
  - state=IDLE, grant=0, count=0, done never asserts, last=done_id.
- Undefined:
  - The run always completes to tgt_q and enters DONE with done=1 for at least one cycle.
  - Because req is already low, the next edge returns to IDLE.

Test Plan:
- Reset then single request: req=0001, tgt[0]=3 -> grant=0001 at edge 1; count 0,1,2,3; done=1 at edge 5; drop req -> grant=0 and done=0 next edge.
- Zero and max target: tgt=0 -> done at edge 2 with count=0; tgt=7 -> done at edge 9 with count=7, no wrap to 0.
- Round robin: req=1111 held, all tgt=1, each requester drops req one cycle after its done -> grant order 0001,0010,0100,1000,0001, with one idle cycle between grants.
- Late request and tgt change: req[2] rises during requester 0's RUN and tgt[0] changes 3->6 mid-run -> run 0 still finishes at count=3; requester 2 is granted after requester 0's DONE->IDLE.
- Early req drop at count=1 with tgt=5 -> with COUNTER_SHARE_ARB_ABORT_EN: grant=0 next edge, done never high; without it: count reaches 5, done high for exactly 1 cycle, then IDLE.
- Async reset mid-run: rst_n low at count=2 -> all outputs 0 immediately, without waiting for clk; after release, req=0011 -> requester 0 is granted first.

Source files
------------

// File: rtl/counter_share_arb.sv
// Round-robin scheduler granting one shared CNT_W-bit up-counter to NUM_REQ requesters,
// with a four-phase req/done handshake. Define COUNTER_SHARE_ARB_ABORT_EN to let a req drop abort a run.
module counter_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] tgt,
  output logic [NUM_REQ-1:0]       grant,
  output logic [CNT_W-1:0]         count,
  output logic                     busy,
  output logic                     done,
  output logic [IDW-1:0]           done_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [CNT_W-1:0]   tgt_q_reg, tgt_q_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [IDW-1:0]     done_id_reg, done_id_next;
  logic [IDW-1:0]     last_reg, last_next;

  logic [CNT_W-1:0]   tgt_arr [NUM_REQ];
  logic [IDW-1:0]     sel;
  logic               found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tgt
      assign tgt_arr[gi] = tgt[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // Scan from last+NUM_REQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    int idx;
    logic [IDW-1:0] idx_b;
    sel   = last_reg;
    found = 1'b0;
    idx   = 0;
    idx_b = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_b = IDW'(idx);
      if (req[idx_b]) begin
        sel   = idx_b;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      count_reg   <= '0;
      tgt_q_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      last_reg    <= IDW'(NUM_REQ - 1);
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      count_reg   <= count_next;
      tgt_q_reg   <= tgt_q_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
      last_reg    <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    count_next   = count_reg;
    tgt_q_next   = tgt_q_reg;
    busy_next    = busy_reg;
    done_next    = done_reg;
    done_id_next = done_id_reg;
    last_next    = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          state_next      = ST_RUN;
          grant_next      = '0;
          grant_next[sel] = 1'b1;
          done_id_next    = sel;
          tgt_q_next      = tgt_arr[sel];
          count_next      = '0;
          busy_next       = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef COUNTER_SHARE_ARB_ABORT_EN
        if (!req[done_id_reg]) begin
          state_next = ST_IDLE;
          grant_next = '0;
          count_next = '0;
          busy_next  = 1'b0;
          done_next  = 1'b0;
          last_next  = done_id_reg;
        end else
`endif
        if (count_reg == tgt_q_reg) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Owner dropping req closes the handshake; it becomes lowest priority next round.
        if (!req[done_id_reg]) begin
          state_next = ST_IDLE;
          grant_next = '0;
          count_next = '0;
          busy_next  = 1'b0;
          done_next  = 1'b0;
          last_next  = done_id_reg;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        count_next = '0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

  assign grant   = grant_reg;
  assign count   = count_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;

endmodule
